fill_rect_engine: RTL and testbench

Parametrised rectangle-fill engine, the next generation of the full-screen fill: it paints any axis-aligned rectangle of a configurable framebuffer with one of four colour modes. The block scans column-major, one pixel per accepted cycle, under backpressure. It sits between the task-level controller (start/done handshake) and the VGA adapter plot port (vga_x/vga_y/vga_colour/vga_plot).

---
 rtl/fill_rect_engine_pkg.sv | 21 ++
 rtl/fill_rect_engine_if.sv | 24 ++
 rtl/fill_rect_engine_scan_counter.sv | 55 +++++
 rtl/fill_rect_engine.sv | 134 +++++++++++++
 tb/tb_fill_rect_engine.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fill_rect_engine_pkg.sv
// Shared types and default dimensions for the rectangle-fill engine.
package fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLOT,
        DONE
    } fill_state_e;

    typedef enum logic [1:0] {
        MODE_SOLID,
        MODE_COL,
        MODE_ROW,
        MODE_DIAG
    } fill_mode_e;

    localparam int unsigned FILL_SCREEN_W = 160;
    localparam int unsigned FILL_SCREEN_H = 120;
    localparam int unsigned FILL_COLOUR_W = 3;

endpackage

// File: rtl/fill_rect_engine_if.sv
// VGA adapter plot port: pixel coordinate/colour with valid (plot) and ready.
interface fill_rect_engine_if #(
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 7,
    parameter int unsigned COLOUR_W = 3
) ();

    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                vga_ready;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot,
        input  vga_ready
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot,
        output vga_ready
    );

endinterface

// File: rtl/fill_rect_engine_scan_counter.sv
// Column-major nested x/y scan counter: y is the fast index, x the slow one.
module fill_scan_counter #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          advance_i,
    input  logic [XW-1:0] x_start_i,
    input  logic [YW-1:0] y_start_i,
    input  logic [YW-1:0] y_first_i,
    input  logic [XW-1:0] x_last_i,
    input  logic [YW-1:0] y_last_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next position: load the corner, or step down the column and wrap to the next one.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = x_start_i;
            y_d = y_start_i;
        end else if (advance_i) begin
            if (y_q == y_last_i) begin
                y_d = y_first_i;
                x_d = x_q + XW'(1);
            end else begin
                y_d = y_q + YW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x_last_i) && (y_q == y_last_i);

endmodule

// File: rtl/fill_rect_engine.sv
// Rectangle-fill engine: paints an inclusive rectangle column-major, one pixel
// per accepted cycle, in one of four colour modes.
// Optional macro FILL_CLIP_EN clamps bounds to the framebuffer.
module fill_rect_engine
    import fill_pkg::*;
#(
    parameter int unsigned SCREEN_W = FILL_SCREEN_W,
    parameter int unsigned SCREEN_H = FILL_SCREEN_H,
    parameter int unsigned COLOUR_W = FILL_COLOUR_W,
    localparam int unsigned XW      = $clog2(SCREEN_W),
    localparam int unsigned YW      = $clog2(SCREEN_H)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [XW-1:0]       x0,
    input  logic [XW-1:0]       x1,
    input  logic [YW-1:0]       y0,
    input  logic [YW-1:0]       y1,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [1:0]          mode,
    fill_rect_engine_if.master  vga,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLOT = PLOT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state_q, state_d;
    logic [XW-1:0]       x1_q;
    logic [YW-1:0]       y0_q, y1_q;
    logic [COLOUR_W-1:0] colour_q;
    fill_mode_e          mode_q;

    logic [XW-1:0]       x1_eff;
    logic [YW-1:0]       y1_eff;
    logic                empty;
    logic                load, advance, last;
    logic [XW-1:0]       x_cur;
    logic [YW-1:0]       y_cur;
    logic [XW:0]         diag_sum;
    logic [COLOUR_W-1:0] pix_colour;

`ifdef FILL_CLIP_EN
    // Clamp far bounds to the screen; an off-screen near corner means nothing to paint.
    always_comb begin
        x1_eff = (32'(x1) > SCREEN_W - 1) ? XW'(SCREEN_W - 1) : x1;
        y1_eff = (32'(y1) > SCREEN_H - 1) ? YW'(SCREEN_H - 1) : y1;
        empty  = (x0 > x1_eff) || (y0 > y1_eff) ||
                 (32'(x0) >= SCREEN_W) || (32'(y0) >= SCREEN_H);
    end
`else
    // Bounds used exactly as presented.
    always_comb begin
        x1_eff = x1;
        y1_eff = y1;
        empty  = (x0 > x1) || (y0 > y1);
    end
`endif

    assign load    = (state_q == ST_IDLE) && start && !empty;
    assign advance = (state_q == ST_PLOT) && vga.vga_ready && !last;

    // Next-state logic: IDLE -> PLOT/DONE on start, PLOT -> DONE on last accept, DONE waits for start low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = empty ? ST_DONE : ST_PLOT;
            ST_PLOT: if (vga.vga_ready && last) state_d = ST_DONE;
            ST_DONE: if (!start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and operand latches (captured only when a fill is accepted in IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            mode_q   <= MODE_SOLID;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start) begin
                x1_q     <= x1_eff;
                y0_q     <= y0;
                y1_q     <= y1_eff;
                colour_q <= colour;
                mode_q   <= fill_mode_e'(mode);
            end
        end
    end

    fill_scan_counter #(
        .XW (XW),
        .YW (YW)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .advance_i (advance),
        .x_start_i (x0),
        .y_start_i (y0),
        .y_first_i (y0_q),
        .x_last_i  (x1_q),
        .y_last_i  (y1_q),
        .x_o       (x_cur),
        .y_o       (y_cur),
        .last_o    (last)
    );

    // Colour decode from latched mode/colour and the current position.
    always_comb begin
        diag_sum = (XW + 1)'(x_cur) + (XW + 1)'(y_cur);
        case (mode_q)
            MODE_COL:  pix_colour = COLOUR_W'(x_cur);
            MODE_ROW:  pix_colour = COLOUR_W'(y_cur);
            MODE_DIAG: pix_colour = COLOUR_W'(diag_sum);
            default:   pix_colour = colour_q;
        endcase
    end

    assign vga.vga_x      = x_cur;
    assign vga.vga_y      = y_cur;
    assign vga.vga_colour = pix_colour;
    assign vga.vga_plot   = (state_q == ST_PLOT);
    assign busy           = (state_q == ST_PLOT);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_fill_rect_engine.sv
// Self-checking bench for fill_rect_engine: directed and randomized fills
// compared against a nested-loop reference of the expected pixel stream.
module tb_fill_rect_engine;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int CW = 3;
    localparam int XW = 8;
    localparam int YW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [CW-1:0] colour;
    logic [1:0]    mode;
    logic          busy, done;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    fill_rect_engine_if #(.XW(XW), .YW(YW), .COLOUR_W(CW)) vif ();

    fill_rect_engine #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .COLOUR_W (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x0     (x0),
        .x1     (x1),
        .y0     (y0),
        .y1     (y1),
        .colour (colour),
        .mode   (mode),
        .vga    (vif),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_colour(input int x, input int y, input int c, input int m);
        case (m)
            1:       return x % (1 << CW);
            2:       return y % (1 << CW);
            3:       return (x + y) % (1 << CW);
            default: return c;
        endcase
    endfunction

    // rdy: 0 = always ready, 1 = random ready, 2 = ready low on PLOT cycles 2 and 3
    task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                            input int ac, input int am, input int rdy, input string tag);
        int ex0, ex1, ey0, ey1;
        int qx[$], qy[$], qc[$];
        int n, idx, plotcyc;
        bit empty;
        bit r;
        logic [31:0] obs, exp;
        ex0 = ax0; ex1 = ax1; ey0 = ay0; ey1 = ay1;
        empty = 1'b0;
`ifdef FILL_CLIP_EN
        if (ex1 > W - 1) ex1 = W - 1;
        if (ey1 > H - 1) ey1 = H - 1;
        if (ex0 >= W || ey0 >= H) empty = 1'b1;
`endif
        if (ex0 > ex1 || ey0 > ey1) empty = 1'b1;
        if (!empty)
            for (int x = ex0; x <= ex1; x++)
                for (int y = ey0; y <= ey1; y++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                    qc.push_back(ref_colour(x, y, ac, am));
                end
        n = qx.size();

        x0 = XW'(ax0); x1 = XW'(ax1); y0 = YW'(ay0); y1 = YW'(ay1);
        colour = CW'(ac); mode = 2'(am);
        vif.vga_ready = 1'b1;
        start = 1'b1;
        step();

        idx = 0;
        plotcyc = 0;
        while (idx < n && plotcyc < 4 * n + 50) begin
            plotcyc++;
            // operands change mid-fill and must be ignored
            x0 = XW'($urandom); x1 = XW'($urandom); y0 = YW'($urandom);
            y1 = YW'($urandom); colour = CW'($urandom); mode = 2'($urandom);
            obs = {12'd0, busy, vif.vga_plot, vif.vga_x, vif.vga_y, vif.vga_colour};
            exp = {12'd0, 1'b1, 1'b1, XW'(qx[idx]), YW'(qy[idx]), CW'(qc[idx])};
            check({tag, " pixel"}, obs, exp);
            case (rdy)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = !(plotcyc == 2 || plotcyc == 3);
            endcase
            vif.vga_ready = r;
            if (r) idx++;
            step();
        end
        if (idx < n) check({tag, " timeout"}, 32'(idx), 32'(n));

        vif.vga_ready = 1'b1;
        check({tag, " done"}, {29'd0, done, busy, vif.vga_plot}, 32'b100);

        // held start with fresh nonempty operands must not retrigger
        x0 = 8'd1; x1 = 8'd3; y0 = 7'd1; y1 = 7'd3;
        step();
        check({tag, " hold"}, {29'd0, done, busy, vif.vga_plot}, 32'b100);

        start = 1'b0;
        step();
        check({tag, " release"}, {29'd0, done, busy, vif.vga_plot}, 32'b000);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        logic [31:0] obs;
        rst = 1'b1; start = 1'b0; vif.vga_ready = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0; mode = '0;
        step();
        step();
        obs = {12'd0, busy, done, vif.vga_plot, vif.vga_x, vif.vga_y, vif.vga_colour};
        check("reset", obs, 32'd0);
        rst = 1'b0;
        step();
        check("idle", {30'd0, busy, done}, 32'd0);

        // full screen, column stripes, continuous ready
        run_fill(0, 159, 0, 119, 0, 1, 0, "full");
        // small solid rect, continuous then stalled on PLOT cycles 2/3
        run_fill(10, 12, 20, 21, 3, 0, 0, "rect");
        run_fill(10, 12, 20, 21, 3, 0, 2, "rect_stall");
        // empty rectangles
        run_fill(5, 4, 10, 12, 2, 0, 0, "empty_x");
        run_fill(5, 7, 12, 10, 2, 0, 0, "empty_y");
        // single pixel
        run_fill(159, 159, 119, 119, 6, 3, 0, "single");

        // reset abandons a fill at its third pixel
        x0 = 8'd2; x1 = 8'd5; y0 = 7'd3; y1 = 7'd6; colour = 3'd7; mode = 2'd3;
        start = 1'b1; vif.vga_ready = 1'b1;
        step(); step(); step();
        check("rst_pix3", {13'd0, vif.vga_plot, vif.vga_x, vif.vga_y, vif.vga_colour},
              {13'd0, 1'b1, 8'd2, 7'd5, 3'd7});
        rst = 1'b1; start = 1'b0;
        step();
        obs = {12'd0, busy, done, vif.vga_plot, vif.vga_x, vif.vga_y, vif.vga_colour};
        check("rst_mid", obs, 32'd0);
        rst = 1'b0;
        step();
        obs = {12'd0, busy, done, vif.vga_plot, vif.vga_x, vif.vga_y, vif.vga_colour};
        check("rst_idle", obs, 32'd0);
        run_fill(40, 41, 50, 52, 0, 2, 1, "after_rst");

`ifdef FILL_CLIP_EN
        run_fill(150, 200, 118, 127, 1, 3, 1, "clip");
        run_fill(170, 180, 10, 12, 1, 0, 0, "clip_empty");
`endif

        // randomized rectangles, modes, colours and backpressure
        for (int i = 0; i < 24; i++) begin
            rx0 = $urandom_range(0, W - 1);
            rx1 = rx0 + $urandom_range(0, 4);
            if (rx1 > W - 1) rx1 = W - 1;
            ry0 = $urandom_range(0, H - 1);
            ry1 = ry0 + $urandom_range(0, 4);
            if (ry1 > H - 1) ry1 = H - 1;
            if ($urandom_range(0, 7) == 0) begin
                int t;
                t = rx0; rx0 = rx1; rx1 = t;
            end
            run_fill(rx0, rx1, ry0, ry1, $urandom_range(0, 7), $urandom_range(0, 3), 1, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
